hazard_ctrl: RTL

// - Pipeline hazard controller for the 5-stage core: drives stall/flush of IF/ID, ID/EX (instr_decode), EX/MEM, MEM/WB.
// - Sequences load-use bubbles, branch/jump redirect flushes and multi-cycle data-memory waits; selects EX operand forwarding.
// - Sits beside the pipeline; consumes stage rd/rs fields and control bits, owns all stall/flush policy.

---
 rtl/hazard_ctrl_pkg.sv | 18 +
 rtl/hazard_ctrl_fwd_unit.sv | 25 ++
 rtl/hazard_ctrl.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared constants for the pipeline hazard controller: result-source code,
// forwarding select encodings and the FSM state type.
package hazard_ctrl_pkg;

    localparam logic [1:0] RES_SRC_MEM = 2'b01;

    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } state_t;

endpackage

// File: rtl/hazard_ctrl_fwd_unit.sv
// Combinational operand forwarding select for one EX source register.
// MEM-stage result takes precedence over WB because it is the younger write.
module hazard_ctrl_fwd_unit
    import hazard_ctrl_pkg::*;
(
    input  logic [4:0] rs_addr,
    input  logic [4:0] mem_rd_addr,
    input  logic       mem_rd_write_enable,
    input  logic [4:0] wb_rd_addr,
    input  logic       wb_rd_write_enable,
    output logic [1:0] sel
);

    always_comb begin
        sel = FWD_REG;
        if (rs_addr != 5'd0) begin
            if (mem_rd_write_enable && (mem_rd_addr == rs_addr)) begin
                sel = FWD_MEM;
            end else if (wb_rd_write_enable && (wb_rd_addr == rs_addr)) begin
                sel = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage core: memory-wait stalls, redirect flushes,
// load-use bubbles, EX forwarding selects and saturating stall/flush counters.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs1_addr,
    input  logic [4:0]       id_rs2_addr,
    input  logic [4:0]       ex_rs1_addr,
    input  logic [4:0]       ex_rs2_addr,
    input  logic [4:0]       ex_rd_addr,
    input  logic             ex_rd_write_enable,
    input  logic [1:0]       ex_res_src,
    input  logic             ex_redirect,
    input  logic [4:0]       mem_rd_addr,
    input  logic             mem_rd_write_enable,
    input  logic             mem_req,
    input  logic             dmem_ready,
    input  logic [4:0]       wb_rd_addr,
    input  logic             wb_rd_write_enable,
    output logic             stall_if,
    output logic             stall_idex,
    output logic             stall_exmem,
    output logic             flush_ifid,
    output logic             flush_idex,
    output logic             flush_memwb,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam int WC_W = $clog2(MEM_TIMEOUT);
    localparam logic [WC_W-1:0] WAIT_LAST = WC_W'(MEM_TIMEOUT - 1);

    state_t           state_reg, state_next;
    logic [WC_W-1:0]  wait_cnt_reg, wait_cnt_next;
    logic             mem_timeout_reg, mem_timeout_next;
    logic [CNT_W-1:0] stall_count_reg, stall_count_next;
    logic [CNT_W-1:0] flush_count_reg, flush_count_next;

    logic mem_stall, timeout_hit, redirect_flush, load_use;
    logic [1:0] fwd_sel [2];
    logic [4:0] ex_rs   [2];

    assign ex_rs[0] = ex_rs1_addr;
    assign ex_rs[1] = ex_rs2_addr;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            hazard_ctrl_fwd_unit u_fwd (
                .rs_addr             (ex_rs[gi]),
                .mem_rd_addr         (mem_rd_addr),
                .mem_rd_write_enable (mem_rd_write_enable),
                .wb_rd_addr          (wb_rd_addr),
                .wb_rd_write_enable  (wb_rd_write_enable),
                .sel                 (fwd_sel[gi])
            );
        end
    endgenerate

    always_comb begin
        state_next       = state_reg;
        wait_cnt_next    = wait_cnt_reg;
        mem_timeout_next = mem_timeout_reg;
        mem_stall        = 1'b0;
        timeout_hit      = 1'b0;
        case (state_reg)
            ST_RUN: begin
                if (mem_req && !dmem_ready) begin
                    mem_stall     = 1'b1;
                    state_next    = ST_MEM_WAIT;
                    wait_cnt_next = '0;
                end
            end
            ST_MEM_WAIT: begin
                if (dmem_ready) begin
                    state_next    = ST_RUN;
                    wait_cnt_next = '0;
                end else if (wait_cnt_reg == WAIT_LAST) begin
                    // Give up on the access so the core cannot hang forever.
                    timeout_hit      = 1'b1;
                    mem_timeout_next = 1'b1;
                    state_next       = ST_RUN;
                    wait_cnt_next    = '0;
                end else begin
                    mem_stall     = 1'b1;
                    wait_cnt_next = wait_cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next    = ST_RUN;
                wait_cnt_next = '0;
            end
        endcase

        redirect_flush = reset && ex_redirect && !mem_stall;
        load_use = reset && !mem_stall && !ex_redirect
                   && (ex_res_src == RES_SRC_MEM) && ex_rd_write_enable
                   && (ex_rd_addr != 5'd0)
                   && ((ex_rd_addr == id_rs1_addr) || (ex_rd_addr == id_rs2_addr));

        // Outputs are forced quiet while reset is held, even though they are combinational.
        stall_if    = reset && (mem_stall || load_use);
        stall_idex  = reset && mem_stall;
        stall_exmem = reset && mem_stall;
        flush_memwb = reset && mem_stall;
        flush_ifid  = redirect_flush;
        flush_idex  = redirect_flush || load_use;
        fwd_a_sel   = reset ? fwd_sel[0] : FWD_REG;
        fwd_b_sel   = reset ? fwd_sel[1] : FWD_REG;
        mem_timeout = mem_timeout_reg || (reset && timeout_hit);

        stall_count_next = stall_count_reg;
        if (stall_if && (stall_count_reg != {CNT_W{1'b1}})) begin
            stall_count_next = stall_count_reg + 1'b1;
        end
        flush_count_next = flush_count_reg;
        if (redirect_flush && (flush_count_reg != {CNT_W{1'b1}})) begin
            flush_count_next = flush_count_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg       <= ST_RUN;
            wait_cnt_reg    <= '0;
            mem_timeout_reg <= 1'b0;
            stall_count_reg <= '0;
            flush_count_reg <= '0;
        end else begin
            state_reg       <= state_next;
            wait_cnt_reg    <= wait_cnt_next;
            mem_timeout_reg <= mem_timeout_next;
            stall_count_reg <= stall_count_next;
            flush_count_reg <= flush_count_next;
        end
    end

    assign stall_count = stall_count_reg;
    assign flush_count = flush_count_reg;

endmodule
